hct138_decoder: RTL and testbench

//   Registered 3-to-8 line decoder/demultiplexer modelled on the 74HCT138.

---
 rtl/hct138_pkg.sv | 15 +
 rtl/hct138_decoder_if.sv | 28 ++
 rtl/hct138_core.sv | 24 ++
 rtl/hct138_decoder.sv | 64 ++++++
 tb/tb_hct138_decoder.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/hct138_pkg.sv
// ----------------------------------------------------------------------------
// hct138_pkg
//   Shared constants for the registered 74HCT138-style 3-to-8 decoder.
//   SEL_W  : width of the {C,B,A} select code
//   N_OUT  : number of decoded outputs (Y0..Y7)
//   Y_IDLE : output vector with every active-low line inactive
// ----------------------------------------------------------------------------
package hct138_pkg;

    localparam int SEL_W = 3;
    localparam int N_OUT = 8;

    localparam logic [N_OUT-1:0] Y_IDLE = 8'hFF;

endpackage : hct138_pkg

// File: rtl/hct138_decoder_if.sv
// ----------------------------------------------------------------------------
// hct138_decoder_if
//   Pin-level bundle of the decoder: three enables, three select bits and the
//   eight active-low decoded outputs.
//   master : drives G, G_2A, G_2B, A, B, C; observes Y0..Y7
//   slave  : the decoder side; consumes enables/selects, drives Y0..Y7
// ----------------------------------------------------------------------------
interface hct138_decoder_if;

    logic G;      // enable G1, active-high
    logic G_2A;   // enable G2A, active-low
    logic G_2B;   // enable G2B, active-low
    logic A;      // select bit 0 (LSB)
    logic B;      // select bit 1
    logic C;      // select bit 2 (MSB)
    logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;  // decoded outputs, active-low

    modport master (
        output G, G_2A, G_2B, A, B, C,
        input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7
    );

    modport slave (
        input  G, G_2A, G_2B, A, B, C,
        output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7
    );

endinterface : hct138_decoder_if

// File: rtl/hct138_core.sv
// ----------------------------------------------------------------------------
// hct138_core
//   Combinational decode: drives the selected line low when enabled, all lines
//   high otherwise.
//   en_i   : combined enable (G & ~G_2A & ~G_2B)
//   sel_i  : select code {C,B,A}
//   y_n_o  : active-low one-cold output vector, bit k = Yk
// ----------------------------------------------------------------------------
module hct138_core
    import hct138_pkg::*;
(
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [N_OUT-1:0] y_n_o
);

    always_comb begin
        y_n_o = Y_IDLE;
        if (en_i) begin
            y_n_o[sel_i] = 1'b0;
        end
    end

endmodule : hct138_core

// File: rtl/hct138_decoder.sv
// ----------------------------------------------------------------------------
// hct138_decoder
//   3-to-8 active-low decoder/demultiplexer modelled on the 74HCT138, with an
//   optional output register for use as a chip-select decoder in synchronous
//   logic.
//   REG_OUT : 1 = Y registered (one-cycle latency), 0 = combinational
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, forces all Y inactive (high)
//   bus     : enables G/G_2A/G_2B, selects A/B/C, outputs Y0..Y7
// ----------------------------------------------------------------------------
module hct138_decoder
    import hct138_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    hct138_decoder_if.slave   bus
);

    logic             en;
    logic [SEL_W-1:0] sel;
    logic [N_OUT-1:0] y_d;
    logic [N_OUT-1:0] y;

    assign en  = bus.G & ~bus.G_2A & ~bus.G_2B;
    assign sel = {bus.C, bus.B, bus.A};

    hct138_core u_core (
        .en_i  (en),
        .sel_i (sel),
        .y_n_o (y_d)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [N_OUT-1:0] y_q;

            // Whole vector is flopped together, so a select change never
            // exposes an intermediate two-low or all-high pattern.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q <= Y_IDLE;
                end else begin
                    y_q <= y_d;
                end
            end

            assign y = y_q;
        end else begin : g_comb
            assign y = y_d;
        end
    endgenerate

    assign bus.Y0 = y[0];
    assign bus.Y1 = y[1];
    assign bus.Y2 = y[2];
    assign bus.Y3 = y[3];
    assign bus.Y4 = y[4];
    assign bus.Y5 = y[5];
    assign bus.Y6 = y[6];
    assign bus.Y7 = y[7];

endmodule : hct138_decoder

// File: tb/tb_hct138_decoder.sv
// ----------------------------------------------------------------------------
// tb_hct138_decoder
//   Drives a registered and a combinational decoder from the same stimulus and
//   compares both against a behavioural model every cycle, with directed
//   scenarios pinned by literal expected values.
// ----------------------------------------------------------------------------
module tb_hct138_decoder;

    logic clk;
    logic rst;

    hct138_decoder_if bus_r ();
    hct138_decoder_if bus_c ();

    hct138_decoder #(.REG_OUT(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
    hct138_decoder #(.REG_OUT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int tests  = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus shadow, shared by both DUT instances.
    logic       g, g2a, g2b;
    logic [2:0] sel;

    assign bus_r.G = g;  assign bus_r.G_2A = g2a;  assign bus_r.G_2B = g2b;
    assign bus_r.A = sel[0];  assign bus_r.B = sel[1];  assign bus_r.C = sel[2];
    assign bus_c.G = g;  assign bus_c.G_2A = g2a;  assign bus_c.G_2B = g2b;
    assign bus_c.A = sel[0];  assign bus_c.B = sel[1];  assign bus_c.C = sel[2];

    function automatic logic [7:0] y_of_r();
        return {bus_r.Y7, bus_r.Y6, bus_r.Y5, bus_r.Y4,
                bus_r.Y3, bus_r.Y2, bus_r.Y1, bus_r.Y0};
    endfunction

    function automatic logic [7:0] y_of_c();
        return {bus_c.Y7, bus_c.Y6, bus_c.Y5, bus_c.Y4,
                bus_c.Y3, bus_c.Y2, bus_c.Y1, bus_c.Y0};
    endfunction

    // Reference: output k is low exactly when all enables are asserted and
    // the numeric select value equals k.
    function automatic logic [7:0] ref_decode(logic fg, logic fa, logic fb, logic [2:0] fs);
        logic [7:0] r;
        int         code;
        bit         on;
        on   = (fg == 1'b1) && (fa == 1'b0) && (fb == 1'b0);
        code = int'(fs);
        for (int k = 0; k < 8; k++) r[k] = (on && code == k) ? 1'b0 : 1'b1;
        return r;
    endfunction

    // Registered-output model: value captured at each rising edge.
    logic [7:0] model_q;
    bit         model_vld = 0;

    always @(posedge clk) begin
        if (rst) begin
            model_q   <= 8'hFF;
            model_vld <= 1'b1;
        end else begin
            model_q   <= ref_decode(g, g2a, g2b, sel);
        end
    end

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Continuous compare once the model holds a defined value.
    always @(negedge clk) begin
        if (model_vld) begin
            check("reg_model", y_of_r(), model_q);
            check("comb_model", y_of_c(), ref_decode(g, g2a, g2b, sel));
        end
    end

    task automatic drive(logic fg, logic fa, logic fb, logic [2:0] fs, logic fr);
        g = fg; g2a = fa; g2b = fb; sel = fs; rst = fr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        g = 1'b0; g2a = 1'b1; g2b = 1'b1; sel = 3'd0; rst = 1'b0;
        #2;

        // Reset with arbitrary inputs for two edges.
        drive(1'b1, 1'b0, 1'b0, 3'd4, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
        check("reset_ff", y_of_r(), 8'hFF);

        // Enabled select sweep 0..7.
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, 1'b0, 1'b0, 3'(s), 1'b0);
            if (s == 3) check("sel3", y_of_r(), 8'b1111_0111);
            if (s == 0) check("sel0", y_of_r(), 8'b1111_1110);
        end

        // Disable sweep at sel=5.
        drive(1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
        check("dis_g", y_of_r(), 8'hFF);
        drive(1'b1, 1'b1, 1'b0, 3'd5, 1'b0);
        check("dis_g2a", y_of_r(), 8'hFF);
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
        check("dis_g2b", y_of_r(), 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
        check("reen_sel5", y_of_r(), 8'b1101_1111);

        // Mid-operation reset at sel=6.
        drive(1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
        check("sel6", y_of_r(), 8'b1011_1111);
        drive(1'b1, 1'b0, 1'b0, 3'd6, 1'b1);
        check("mid_rst", y_of_r(), 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
        check("post_rst_sel6", y_of_r(), 8'b1011_1111);

        // Wrap 7 -> 0.
        drive(1'b1, 1'b0, 1'b0, 3'd7, 1'b0);
        check("wrap7", y_of_r(), 8'b0111_1111);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        check("wrap0", y_of_r(), 8'b1111_1110);

        // Combinational build follows inputs without a clock edge.
        g = 1'b1; g2a = 1'b0; g2b = 1'b0; sel = 3'd2;
        #1;
        check("comb_sel2", y_of_c(), 8'b1111_1011);
        g2b = 1'b1;
        #1;
        check("comb_dis", y_of_c(), 8'hFF);
        @(posedge clk);
        #1;

        // Randomized traffic, biased toward enabled, with occasional reset.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 29) == 0));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hct138_decoder
